// File: rtl/uart_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
// uart_tx_arb_pkg: state encoding, tag prefix and width helper for uart_tx_arbiter
// Rev 1.0
// ============================================================================
package uart_tx_arb_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_TAG       = 3'd1;
  localparam logic [2:0] ST_LOAD      = 3'd2;
  localparam logic [2:0] ST_ISSUE     = 3'd3;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd4;
  localparam logic [2:0] ST_WAIT_DONE = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_TAG       = ST_TAG,
    S_LOAD      = ST_LOAD,
    S_ISSUE     = ST_ISSUE,
    S_WAIT_ACK  = ST_WAIT_ACK,
    S_WAIT_DONE = ST_WAIT_DONE
  } arb_state_e;

  localparam logic [7:0] TAG_PREFIX = 8'h80;

  function automatic int grant_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
// uart_rr_pick: round-robin winner, lowest valid index at or above rr_ptr (wrapping)
// Rev 1.0
// ============================================================================
module uart_rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int GW = grant_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [GW-1:0]      rr_ptr,
  output logic [GW-1:0]      winner,
  output logic               any
);

  int          idx;
  logic [GW-1:0] idx_w;

  // Scan from the farthest offset down so the nearest valid index wins last.
  always_comb begin
    winner = '0;
    idx    = 0;
    idx_w  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      idx_w = GW'(idx);
      if (req_valid[idx_w]) begin
        winner = idx_w;
      end
    end
  end

  assign any = |req_valid;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter: round-robin, message-atomic sharing of one UART byte transmitter.
// Optional tag byte per message when UART_TX_ARB_TAG_EN is defined.  Rev 1.0
// ============================================================================
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*8-1:0]             req_data,
  input  logic [NUM_REQ-1:0]               req_last,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [7:0]                       tx_data,
  output logic                             tx_valid,
  input  logic                             tx_busy,
  output logic [grant_width(NUM_REQ)-1:0]  grant_id,
  output logic                             arb_busy,
  output logic                             timeout_pulse
);

  localparam int              GW        = grant_width(NUM_REQ);
  localparam int              SW        = $clog2(IDLE_TIMEOUT);
  localparam logic [SW-1:0]   STALL_MAX = SW'(IDLE_TIMEOUT - 1);
  localparam logic [GW-1:0]   LAST_ID   = GW'(NUM_REQ - 1);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          last_q, last_d;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
`ifdef UART_TX_ARB_TAG_EN
  logic          tag_phase_q, tag_phase_d;
`endif

  logic [GW-1:0] pick_winner;
  logic          pick_any;
  logic [GW-1:0] rr_after_grant;
  logic [7:0]    req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .winner    (pick_winner),
    .any       (pick_any)
  );

  assign rr_after_grant = (grant_id_q == LAST_ID) ? '0 : grant_id_q + GW'(1);

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    tx_data_d     = tx_data_q;
    last_d        = last_q;
    stall_cnt_d   = stall_cnt_q;
`ifdef UART_TX_ARB_TAG_EN
    tag_phase_d   = tag_phase_q;
`endif
    req_ready     = '0;
    timeout_pulse = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!tx_busy && pick_any) begin
          grant_id_d  = pick_winner;
          stall_cnt_d = '0;
`ifdef UART_TX_ARB_TAG_EN
          tag_phase_d = 1'b1;
          state_d     = S_TAG;
`else
          state_d     = S_LOAD;
`endif
        end
      end
`ifdef UART_TX_ARB_TAG_EN
      S_TAG: begin
        tx_data_d = TAG_PREFIX | 8'(grant_id_q);
        state_d   = S_ISSUE;
      end
`endif
      S_LOAD: begin
        // A byte arriving on the last stall cycle is still accepted.
        if (req_valid[grant_id_q]) begin
          req_ready[grant_id_q] = 1'b1;
          tx_data_d             = req_bytes[grant_id_q];
          last_d                = req_last[grant_id_q];
          state_d               = S_ISSUE;
        end else if (stall_cnt_q == STALL_MAX) begin
          timeout_pulse = 1'b1;
          rr_ptr_d      = rr_after_grant;
          state_d       = S_IDLE;
        end else begin
          stall_cnt_d = stall_cnt_q + SW'(1);
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
`ifdef UART_TX_ARB_TAG_EN
          if (tag_phase_q) begin
            tag_phase_d = 1'b0;
            stall_cnt_d = '0;
            state_d     = S_LOAD;
          end else
`endif
          if (last_q) begin
            rr_ptr_d = rr_after_grant;
            state_d  = S_IDLE;
          end else begin
            stall_cnt_d = '0;
            state_d     = S_LOAD;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      tx_data_q   <= 8'h00;
      last_q      <= 1'b0;
      stall_cnt_q <= '0;
`ifdef UART_TX_ARB_TAG_EN
      tag_phase_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      tx_data_q   <= tx_data_d;
      last_q      <= last_d;
      stall_cnt_q <= stall_cnt_d;
`ifdef UART_TX_ARB_TAG_EN
      tag_phase_q <= tag_phase_d;
`endif
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = (state_q == S_ISSUE);
  assign grant_id = grant_id_q;
  assign arb_busy = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter: directed bench with a behavioural 4-clocks-per-bit transmitter
// Rev 1.0
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int CPB  = 4;
`ifdef UART_TX_ARB_TAG_EN
  localparam int TAGN = 1;
`else
  localparam int TAGN = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            tx_rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*8-1:0] req_data = '0;
  logic [NREQ-1:0] req_last = '0;
  logic [NREQ-1:0] req_ready;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_busy;
  logic [1:0]      grant_id;
  logic            arb_busy;
  logic            timeout_pulse;

  uart_tx_arbiter #(
    .NUM_REQ      (NREQ),
    .IDLE_TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_busy       (tx_busy),
    .grant_id      (grant_id),
    .arb_busy      (arb_busy),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Requester sources: queue of {last, data}, presented at the falling edge.
  logic [8:0] src_q [NREQ][$];

  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i]         <= 1'b1;
        req_last[i]          <= src_q[i][0][8];
        req_data[i*8 +: 8]   <= src_q[i][0][7:0];
      end else begin
        req_valid[i] <= 1'b0;
        req_last[i]  <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i] && src_q[i].size() > 0) begin
        void'(src_q[i].pop_front());
      end
    end
  end

  // Transmitter: registered busy, 8N1, not reset by the arbiter's rst.
  logic       tx_line = 1'b1;
  logic [9:0] sh = '0;
  logic [9:0] rxb = '0;
  int         bitn = 0;
  int         clkn = 0;
  int         frame_err = 0;
  logic [7:0] line_q [$];

  always @(posedge clk) begin
    if (tx_rst) begin
      tx_busy <= 1'b0;
      tx_line <= 1'b1;
      clkn    <= 0;
      bitn    <= 0;
    end else if (!tx_busy) begin
      if (tx_valid) begin
        sh      <= {1'b1, tx_data, 1'b0};
        tx_busy <= 1'b1;
        tx_line <= 1'b0;
        clkn    <= 0;
        bitn    <= 0;
      end
    end else begin
      if (clkn == 1) rxb[bitn] <= tx_line;
      if (clkn == CPB - 1) begin
        clkn <= 0;
        if (bitn == 9) begin
          tx_busy <= 1'b0;
          tx_line <= 1'b1;
          line_q.push_back(rxb[8:1]);
          if (rxb[0] !== 1'b0 || rxb[9] !== 1'b1) frame_err <= frame_err + 1;
        end else begin
          bitn    <= bitn + 1;
          tx_line <= sh[bitn+1];
        end
      end else begin
        clkn <= clkn + 1;
      end
    end
  end

  // Event monitor, sampling pre-edge values.
  int   cyc = 0;
  int   fall_cyc = 0;
  int   arb_fall = 0;
  int   rise0 = 0;
  int   viol = 0;
  logic busy_d = 1'b0, arb_d = 1'b0, rv0_d = 1'b0, tv_d = 1'b0;
  int   vcyc_q [$];
  int   vgap_q [$];
  int   glog [$];
  int   to_q [$];

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    busy_d <= tx_busy;
    arb_d  <= arb_busy;
    rv0_d  <= req_valid[0];
    tv_d   <= tx_valid;
    if (busy_d && !tx_busy) fall_cyc <= cyc;
    if (arb_d && !arb_busy) arb_fall <= cyc;
    if (req_valid[0] && !rv0_d) rise0 <= cyc;
    if (tx_valid) begin
      vcyc_q.push_back(cyc);
      vgap_q.push_back(cyc - fall_cyc);
      if (tx_busy === 1'b1 || tv_d) viol <= viol + 1;
    end
    if ($countones(req_ready) > 1) viol <= viol + 1;
    if (|req_ready) glog.push_back(int'(grant_id));
    if (timeout_pulse) to_q.push_back(cyc - fall_cyc);
  end

  logic [7:0] exp_q [$];

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic exp_tag(input int id);
    if (TAGN == 1) exp_q.push_back(8'h80 | 8'(id));
  endtask

  task automatic start_test;
    line_q.delete();
    exp_q.delete();
    vcyc_q.delete();
    vgap_q.delete();
    glog.delete();
    to_q.delete();
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      tick;
      if (line_q.size() >= exp_q.size() && !arb_busy && !tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, 32'(ok), 32'd1);
    tick;
    tick;
  endtask

  task automatic check_line(input string tag);
    check({tag, "_nbytes"}, line_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < line_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(line_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    bit ok;
    int gexp [9];
    gexp = '{3, 0, 1, 2, 3, 0, 1, 2, 3};

    repeat (3) tick;
    rst    = 1'b0;
    tx_rst = 1'b0;
    tick;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_arb_busy", 32'(arb_busy), 32'd0);
    check("rst_timeout", 32'(timeout_pulse), 32'd0);

    // One-byte message from req0.
    start_test;
    src_q[0].push_back({1'b1, 8'h55});
    exp_tag(0); exp_q.push_back(8'h55);
    wait_done("t1");
    check("t1_latency", 32'(vcyc_q[0] - rise0), 32'd2);
    check("t1_busy_fall", 32'(arb_fall - fall_cyc), 32'd1);
    check_line("t1");

    // req1 three-byte message and req2 one-byte message, same start cycle.
    start_test;
    src_q[1].push_back({1'b0, 8'h11});
    src_q[1].push_back({1'b0, 8'h12});
    src_q[1].push_back({1'b1, 8'h13});
    src_q[2].push_back({1'b1, 8'h21});
    exp_tag(1); exp_q.push_back(8'h11); exp_q.push_back(8'h12); exp_q.push_back(8'h13);
    exp_tag(2); exp_q.push_back(8'h21);
    wait_done("t2");
    check_line("t2");
    check("t2_b2b_gap", 32'(vgap_q[TAGN+2]), 32'd2);

    // req3 stalls mid-message; others queue two one-byte messages each.
    start_test;
    src_q[3].push_back({1'b0, 8'hA3});
    for (int i = 0; i < 3; i++) begin
      src_q[i].push_back({1'b1, 8'(8'h30 + i)});
      src_q[i].push_back({1'b1, 8'(8'h40 + i)});
    end
    exp_tag(3); exp_q.push_back(8'hA3);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        exp_tag(i);
        exp_q.push_back(8'(8'h30 + 16*r + i));
      end
    end
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      tick;
      if (to_q.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("t4_timeout_seen", 32'(ok), 32'd1);
    src_q[3].push_back({1'b1, 8'h33});
    src_q[3].push_back({1'b1, 8'h43});
    wait_done("t4");
    check("t4_timeout_count", to_q.size(), 32'd1);
    check("t4_timeout_delay", 32'(to_q[0]), 32'd8);
    check("t3_grants", glog.size(), 32'd9);
    for (int i = 0; i < 9 && i < glog.size(); i++) begin
      check($sformatf("t3_grant%0d", i), 32'(glog[i]), 32'(gexp[i]));
    end
    check_line("t34");

    // Tag byte (present only when the tag feature is built in).
    start_test;
    src_q[2].push_back({1'b1, 8'h3C});
    exp_tag(2); exp_q.push_back(8'h3C);
    wait_done("t5");
    check_line("t5");

    // Reset while req0's second byte is on the line.
    start_test;
    src_q[0].push_back({1'b0, 8'h61});
    src_q[0].push_back({1'b1, 8'h62});
    exp_tag(0); exp_q.push_back(8'h61); exp_q.push_back(8'h62);
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      tick;
      if (vcyc_q.size() >= TAGN + 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("t6_second_issue", 32'(ok), 32'd1);
    repeat (5) tick;
    rst = 1'b1;
    #1;
    check("t6_rst_arb_busy", 32'(arb_busy), 32'd0);
    check("t6_rst_tx_data", 32'(tx_data), 32'h00);
    check("t6_rst_grant_id", 32'(grant_id), 32'd0);
    check("t6_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("t6_rst_req_ready", 32'(req_ready), 32'd0);
    check("t6_tx_still_busy", 32'(tx_busy), 32'd1);
    tick;
    rst = 1'b0;
    src_q[1].push_back({1'b1, 8'h71});
    exp_tag(1); exp_q.push_back(8'h71);
    wait_done("t6");
    check_line("t6");
    check("t6_issues", vcyc_q.size(), 32'(2*TAGN + 3));
    check("t6_regrant_gap", 32'(vgap_q[TAGN+2]), 32'd2);

    check("protocol_violations", 32'(viol), 32'd0);
    check("frame_errors", 32'(frame_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART byte transmitter between `NUM_REQ` byte-stream requesters (debug/status sources in the Ethernet subsystem). The block grants requesters round-robin, holds each grant for a whole message (until the `last` byte), and paces bytes into the transmitter with a `data_valid`/`tx_busy` handshake. Bytes from different requesters never interleave on the line.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `IDLE_TIMEOUT`, 1024: cycles a granted requester may stall mid-message before the grant is revoked. Must be at least 2.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in `NUM_REQ`: per-requester byte valid.
- `req_data` in `NUM_REQ*8`: byte of requester i at bits `[8i+7:8i]`.
- `req_last` in `NUM_REQ`: byte is the final byte of the message.
- `req_ready` out `NUM_REQ`: one-hot accept strobe, combinational.
- `tx_data` out 8: byte to the transmitter (`data_in`).
- `tx_valid` out 1: one-cycle start strobe to the transmitter (`data_valid`).
- `tx_busy` in 1: transmitter busy, registered by the transmitter.
- `grant_id` out `$clog2(NUM_REQ)`: current or last grantee.
- `arb_busy` out 1: high in every state except IDLE.
- `timeout_pulse` out 1: one-cycle pulse when a grant is revoked.

## Operation
- States: IDLE, TAG, LOAD, ISSUE, WAIT_ACK, WAIT_DONE.
- **IDLE**
  - Leaves IDLE only if `tx_busy==0` and some `req_valid` bit is set.
  - The winner is the lowest index at or above `rr_ptr`, wrapping. It is registered into `grant_id`.
  - Next state is TAG if the tag feature is compiled in, otherwise LOAD.
- **TAG**
  - `tx_data = TAG_PREFIX | grant_id` (`TAG_PREFIX = 8'h80`), `tag_phase = 1`.
  - Next state is ISSUE.
- **LOAD**
  - If `req_valid[grant_id]` is high: `req_ready[grant_id] = 1` in the same cycle, latch the byte into `tx_data` and the last flag into `last_reg`, then go to ISSUE.
  - Otherwise `stall_cnt` increments.
  - When `stall_cnt == IDLE_TIMEOUT-1`: `timeout_pulse = 1`, `rr_ptr = grant_id+1` (mod `NUM_REQ`), go to IDLE.
  - `stall_cnt` clears on every entry to LOAD.
- **ISSUE**: `tx_valid = 1` for exactly one cycle, then WAIT_ACK.
- **WAIT_ACK**: wait for `tx_busy==1`, then WAIT_DONE.
- **WAIT_DONE**: wait for `tx_busy==0`, then:
  - if `tag_phase` is set: clear it, go to LOAD;
  - else if `last_reg` is set: `rr_ptr = grant_id+1` (mod `NUM_REQ`), go to IDLE;
  - else go to LOAD.
- `req_ready` is zero outside LOAD, and at most one bit is ever high.
- Arithmetic: `rr_ptr` and `grant_id` wrap modulo `NUM_REQ`, not modulo a power of two. `stall_cnt` is `$clog2(IDLE_TIMEOUT)` bits and saturates at the timeout.
- A message whose first byte has `req_last=1` is a one-byte message.

## Timing
- Reset values: `req_ready=0`, `tx_data=8'h00`, `tx_valid=0`, `grant_id=0`, `arb_busy=0`, `timeout_pulse=0`. Internal `rr_ptr=0`, `tag_phase=0`, state IDLE.
- Reset mid-operation aborts the message. An in-flight transmitter byte is not re-issued. After reset the block does not grant until `tx_busy` is seen low.
- Latency without tag, requester valid while in IDLE:
  - cycle 0: IDLE, grant registered;
  - cycle 1: LOAD, `req_ready` pulse;
  - cycle 2: ISSUE, `tx_valid`;
  - cycle 3: `tx_busy` rises.
- Back-to-back bytes in one message: the next `tx_valid` comes 2 cycles after `tx_busy` falls (WAIT_DONE, then LOAD, then ISSUE).
- Simultaneous requests: round-robin order is strictly fair. A requester that raises `req_valid` while another holds the grant waits for that message's `last` byte or a timeout.

## Configuration
- `UART_TX_ARB_TAG_EN` defined: every message is preceded by the tag byte `8'h80|grant_id`. The tag is sent before any requester byte is accepted.
- Not defined: the TAG state and `tag_phase` are removed, and IDLE goes directly to LOAD.

## Structure
- Package `uart_tx_arb_pkg` holds:
  - the state enum `arb_state_e`;
  - `TAG_PREFIX`;
  - a function returning the `grant_id` width for a given `NUM_REQ`.
- Sub-module `uart_rr_pick` (combinational): inputs `req_valid` and `rr_ptr`; outputs `winner` and `any`. It is the only pure-logic piece.

## Test plan
Bench uses the real transmitter with `CLKS_PER_BIT=4` and `NUM_REQ=4`.
- Single one-byte message: req0 sends `8'h55` with last. Expected: `tx_valid` 2 cycles after `req_valid`, line shows start, `0x55` LSB-first, stop; `arb_busy` falls after `tx_busy` falls.
- Non-interleaving: req1 sends `{11,12,13(last)}` while req2 sends `{21(last)}`, both starting the same cycle. Expected line order 11,12,13,21.
- Fairness: all 4 requesters hold 1-byte messages continuously for 8 grants. Expected `grant_id` sequence 0,1,2,3,0,1,2,3.
- Timeout: `IDLE_TIMEOUT=8`; req3 sends one non-last byte, then drops valid. Expected: `timeout_pulse` 8 cycles after entering LOAD, then req0 is granted next.
- Tag (`UART_TX_ARB_TAG_EN`): req2 sends `8'h3C` with last. Expected bytes on the line: `0x82`, `0x3C`.
- Reset mid-byte: assert `rst` during req0's second byte. Expected: outputs return to reset values immediately, and there is no `tx_valid` until `tx_busy` drops.
